// File: rtl/fma_norm_round_if.sv
// Valid/ready stream bundle for the FMA post-add normaliser/rounder.
// The master side drives input beats and out_ready. The slave side is the rounder.
interface fma_norm_round_if #(
  parameter int unsigned EXP_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [47:0]      in_mant;
  logic             in_g;
  logic             in_r;
  logic             in_s;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_overflow;
  logic             out_underflow;
  logic             out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_g, in_r, in_s, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_g, in_r, in_s, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fma_norm_round.sv
// FMA post-add normaliser and round-to-nearest-even packer for single precision.
// The three stages (LZC, shift, round/pack) advance in lockstep under one stall signal.
module fma_norm_round #(
  parameter int unsigned EXP_W = 10
) (
  input logic              clk,
  input logic              rst_n,
  fma_norm_round_if.slave  bus_io
);
  localparam int unsigned EW = EXP_W + 1;

  logic adv;
  assign adv             = bus_io.out_ready | ~bus_io.out_valid;
  assign bus_io.in_ready = adv;

  // Stage 1: leading-zero count
  logic [49:0]   s1_x_d;
  logic [5:0]    s1_lz_d;
  logic [EW-1:0] s1_exp_d;

  always_comb begin
    s1_x_d  = {bus_io.in_mant, bus_io.in_g, bus_io.in_r};
    s1_lz_d = 6'd50;
    // Ascending scan: the highest set bit is the last to write.
    for (int i = 0; i < 50; i++) begin
      if (s1_x_d[i]) s1_lz_d = 6'(49 - i);
    end
    s1_exp_d = {bus_io.in_exp[EXP_W-1], bus_io.in_exp} + EW'(1) - EW'(s1_lz_d);
  end

  logic          s1_valid_q, s1_s_q, s1_sign_q, s1_zero_q;
  logic [49:0]   s1_x_q;
  logic [5:0]    s1_lz_q;
  logic [EW-1:0] s1_exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_x_q     <= '0;
      s1_lz_q    <= '0;
      s1_exp_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= bus_io.in_valid;
      s1_s_q     <= bus_io.in_s;
      s1_sign_q  <= bus_io.in_sign;
      s1_zero_q  <= (s1_x_d == '0);
      s1_x_q     <= s1_x_d;
      s1_lz_q    <= s1_lz_d;
      s1_exp_q   <= s1_exp_d;
    end
  end

  // Stage 2: normalising left shift
  logic [49:0] s2_n;
  logic [23:0] s2_sig_d;
  logic        s2_g_d, s2_s_d;

  always_comb begin
    s2_n     = s1_x_q << s1_lz_q;
    s2_sig_d = s2_n[49:26];
    s2_g_d   = s2_n[25];
    s2_s_d   = (|s2_n[24:0]) | s1_s_q;
  end

  logic          s2_valid_q, s2_g_q, s2_s_q, s2_sign_q, s2_zero_q;
  logic [23:0]   s2_sig_q;
  logic [EW-1:0] s2_exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_g_q     <= 1'b0;
      s2_s_q     <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_sig_q   <= '0;
      s2_exp_q   <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_g_q     <= s2_g_d;
      s2_s_q     <= s2_s_d;
      s2_sign_q  <= s1_sign_q;
      s2_zero_q  <= s1_zero_q;
      s2_sig_q   <= s2_sig_d;
      s2_exp_q   <= s1_exp_q;
    end
  end

  // Stage 3: round to nearest even and pack
  logic              inc, carry, inexact;
  logic [23:0]       sum;
  logic signed [EW:0] exp_f;
  logic [31:0]       res_d;
  logic              ovf_d, unf_d, inx_d;

  always_comb begin
    inc     = s2_g_q & (s2_s_q | s2_sig_q[0]);
    sum     = s2_sig_q + 24'(inc);
    // A normalised significand only loses its hidden bit when the increment carries out.
    carry   = s2_sig_q[23] & ~sum[23];
    exp_f   = {s2_exp_q[EW-1], s2_exp_q} + (EW + 1)'(carry);
    inexact = s2_g_q | s2_s_q;
    res_d   = {s2_sign_q, exp_f[7:0], sum[22:0]};
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    inx_d   = inexact;
    if (s2_zero_q) begin
      res_d = {s2_sign_q, 31'b0};
      unf_d = s2_s_q;
      inx_d = s2_s_q;
    end else if (exp_f >= 255) begin
      res_d = {s2_sign_q, 8'hFF, 23'b0};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (exp_f <= 0) begin
      res_d = {s2_sign_q, 31'b0};
      unf_d = 1'b1;
    end
  end

  logic        out_valid_q, ovf_q, unf_q, inx_q;
  logic [31:0] res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        inx_q <= inx_d;
      end
    end
  end

  assign bus_io.out_valid     = out_valid_q;
  assign bus_io.out_result    = res_q;
  assign bus_io.out_overflow  = ovf_q;
  assign bus_io.out_underflow = unf_q;
  assign bus_io.out_inexact   = inx_q;

endmodule

// File: tb/tb_fma_norm_round.sv
// Directed bench for fma_norm_round: rounding, boundaries, backpressure and reset.
module tb_fma_norm_round;
  localparam int unsigned EXP_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fma_norm_round_if #(.EXP_W(EXP_W)) bus_if ();

  fma_norm_round #(.EXP_W(EXP_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_if.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic idle_inputs();
    bus_if.in_valid  = 1'b0;
    bus_if.in_sign   = 1'b0;
    bus_if.in_exp    = '0;
    bus_if.in_mant   = '0;
    bus_if.in_g      = 1'b0;
    bus_if.in_r      = 1'b0;
    bus_if.in_s      = 1'b0;
    bus_if.out_ready = 1'b1;
  endtask

  // Drives one beat into an empty pipeline and waits (bounded) for its result.
  task automatic send(input logic sgn, input logic [EXP_W-1:0] e, input logic [47:0] m,
                      input logic g, input logic r, input logic s,
                      output logic [31:0] res, output logic [2:0] fl, output int lat);
    @(posedge clk); #1;
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.in_sign   = sgn;
    bus_if.in_exp    = e;
    bus_if.in_mant   = m;
    bus_if.in_g      = g;
    bus_if.in_r      = r;
    bus_if.in_s      = s;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    lat = 1;
    while (!bus_if.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus_if.out_result;
    fl  = {bus_if.out_overflow, bus_if.out_underflow, bus_if.out_inexact};
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b expected 0", bus_if.out_valid);
    end
    checks++;
    if (bus_if.out_result !== 32'h0) begin
      failures++; $display("FAIL reset_result: got %h expected 00000000", bus_if.out_result);
    end
    checks++;
    if ({bus_if.out_overflow, bus_if.out_underflow, bus_if.out_inexact} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b%b%b expected 000", bus_if.out_overflow,
                           bus_if.out_underflow, bus_if.out_inexact);
    end
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] res; logic [2:0] fl; int lat;
    send(1'b0, 10'd127, 48'h400000000000, 1'b0, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    checks++;
    if (res !== 32'h3F800000) begin
      failures++; $display("FAIL basic_result: got %h expected 3f800000", res);
    end
    checks++;
    if (fl !== 3'b000) begin failures++; $display("FAIL basic_flags: got %b expected 000", fl); end
    send(1'b0, 10'd127, 48'h800000000000, 1'b0, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 32'h40000000 || fl !== 3'b000) begin
      failures++; $display("FAIL carry_bit: got %h/%b expected 40000000/000", res, fl);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] res; logic [2:0] fl; int lat;
    send(1'b0, 10'd127, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 32'h40000000 || fl !== 3'b001) begin
      failures++; $display("FAIL round_carry: got %h/%b expected 40000000/001", res, fl);
    end
    send(1'b0, 10'd127, 48'h400000400000, 1'b0, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 32'h3F800000 || fl !== 3'b001) begin
      failures++; $display("FAIL tie_even: got %h/%b expected 3f800000/001", res, fl);
    end
    send(1'b0, 10'd127, 48'h400000400000, 1'b0, 1'b0, 1'b1, res, fl, lat);
    checks++;
    if (res !== 32'h3F800001 || fl !== 3'b001) begin
      failures++; $display("FAIL above_tie: got %h/%b expected 3f800001/001", res, fl);
    end
    send(1'b0, 10'd127, 48'h400000000000, 1'b1, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 32'h3F800000 || fl !== 3'b001) begin
      failures++; $display("FAIL guard_sticky: got %h/%b expected 3f800000/001", res, fl);
    end
  endtask

  task automatic test_normalise();
    logic [31:0] res; logic [2:0] fl; int lat;
    send(1'b0, 10'd173, 48'h000000000001, 1'b0, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 32'h3F800000 || fl !== 3'b000) begin
      failures++; $display("FAIL deep_norm: got %h/%b expected 3f800000/000", res, fl);
    end
    send(1'b1, 10'd174, 48'h000000000000, 1'b1, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 32'hBF800000 || fl !== 3'b000) begin
      failures++; $display("FAIL guard_only: got %h/%b expected bf800000/000", res, fl);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] res; logic [2:0] fl; int lat;
    send(1'b0, 10'd254, 48'h800000000000, 1'b0, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 32'h7F800000 || fl !== 3'b101) begin
      failures++; $display("FAIL overflow: got %h/%b expected 7f800000/101", res, fl);
    end
    send(1'b1, 10'd254, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 32'hFF800000 || fl !== 3'b101) begin
      failures++; $display("FAIL round_overflow: got %h/%b expected ff800000/101", res, fl);
    end
    send(1'b0, 10'd0, 48'h400000000000, 1'b0, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 32'h00000000 || fl !== 3'b010) begin
      failures++; $display("FAIL underflow: got %h/%b expected 00000000/010", res, fl);
    end
    send(1'b0, 10'd1, 48'h400000000000, 1'b0, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 32'h00800000 || fl !== 3'b000) begin
      failures++; $display("FAIL min_normal: got %h/%b expected 00800000/000", res, fl);
    end
    send(1'b0, 10'h3FB, 48'h400000000000, 1'b0, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 32'h00000000 || fl !== 3'b010) begin
      failures++; $display("FAIL neg_exp: got %h/%b expected 00000000/010", res, fl);
    end
    send(1'b1, 10'd127, 48'h000000000000, 1'b0, 1'b0, 1'b0, res, fl, lat);
    checks++;
    if (res !== 32'h80000000 || fl !== 3'b000) begin
      failures++; $display("FAIL neg_zero: got %h/%b expected 80000000/000", res, fl);
    end
    send(1'b0, 10'd127, 48'h000000000000, 1'b0, 1'b0, 1'b1, res, fl, lat);
    checks++;
    if (res !== 32'h00000000 || fl !== 3'b011) begin
      failures++; $display("FAIL sticky_zero: got %h/%b expected 00000000/011", res, fl);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    logic        held;
    logic [31:0] held_val;
    int          stalls;
    held   = 1'b0;
    held_val = '0;
    stalls = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          logic ok;
          int   guard;
          guard = 0;
          bus_if.in_valid = 1'b1;
          bus_if.in_sign  = 1'b0;
          bus_if.in_exp   = 10'(120 + k);
          bus_if.in_mant  = 48'h400000000000;
          bus_if.in_g     = 1'b0;
          bus_if.in_r     = 1'b0;
          bus_if.in_s     = 1'b0;
          do begin
            @(negedge clk);
            ok = bus_if.in_ready;
            @(posedge clk); #1;
            guard++;
          end while (!ok && guard < 50);
        end
        bus_if.in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus_if.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus_if.out_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (bus_if.out_valid && held) begin
            checks++;
            if (bus_if.out_result !== held_val) begin
              failures++;
              $display("FAIL held_stable: got %h expected %h", bus_if.out_result, held_val);
            end
          end
          if (bus_if.out_valid && !bus_if.out_ready) begin
            stalls++;
            checks++;
            if (bus_if.in_ready !== 1'b0) begin
              failures++; $display("FAIL stall_in_ready: got %b expected 0", bus_if.in_ready);
            end
          end
          if (bus_if.out_valid && bus_if.out_ready) got.push_back(bus_if.out_result);
          held     = bus_if.out_valid && !bus_if.out_ready;
          held_val = bus_if.out_result;
        end
      end
    join
    checks++;
    if (stalls != 4) begin
      failures++; $display("FAIL stall_cycles: got %0d expected 4", stalls);
    end
    checks++;
    if (got.size() != 5) begin
      failures++; $display("FAIL stream_count: got %0d expected 5", got.size());
    end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      logic [31:0] want;
      want = {1'b0, 8'(120 + k), 23'b0};
      checks++;
      if (got[k] !== want) begin
        failures++; $display("FAIL stream_order[%0d]: got %h expected %h", k, got[k], want);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    int seen;
    seen = 0;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.in_sign   = 1'b0;
    bus_if.in_exp    = 10'd127;
    bus_if.in_mant   = 48'h400000000000;
    bus_if.in_g      = 1'b0;
    bus_if.in_r      = 1'b0;
    bus_if.in_s      = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus_if.in_valid = 1'b0;
    checks++;
    if (bus_if.out_valid !== 1'b1) begin
      failures++; $display("FAIL inflight_valid: got %b expected 1", bus_if.out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.out_result !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: got %b/%h expected 0/00000000", bus_if.out_valid,
               bus_if.out_result);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus_if.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL stale_after_reset: got %0d beats expected 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_normalise();
    test_boundaries();
    test_back_to_back();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
